// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: AXI4-Stream source emitting counted packets of incrementing data with TLAST and backpressure.
module axis_pattern_gen #(
  parameter logic [3:0] ID  = 4'h0,
  parameter int         DW  = 32,
  parameter int         LW  = 16,
  parameter int         IPG = 0
) (
  input  logic            gen_clk,
  input  logic            gen_resetn,
  input  logic            gen_start,
  input  logic [LW-1:0]   gen_pkt_len,
  input  logic [LW-1:0]   gen_pkt_num,
  input  logic [DW-1:0]   gen_seed,
  output logic            gen_busy,
  output logic            gen_done,
  output logic            gen_err,
  output logic [31:0]     gen_beat_cnt,
  output logic            gen_o_tvalid,
  input  logic            gen_o_tready,
  output logic [DW-1:0]   gen_o_tdata,
  output logic [DW/8-1:0] gen_o_tkeep,
  output logic [3:0]      gen_o_tdest,
  output logic            gen_o_tlast
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2, S_DONE = 2'd3;
  localparam int GW = IPG > 1 ? $clog2(IPG) : 1;
  logic [1:0]    r_state;
  logic [LW-1:0] r_len, r_num, r_beat, r_pkt;
  logic [GW-1:0] r_gap;
  logic [DW-1:0] r_data;
  logic [31:0]   r_beat_cnt;
  logic          r_tvalid, r_tlast, r_busy, r_done, r_err;
  logic w_xfer, w_pkt_last, w_next_last, w_first_last, w_gap_end;
  assign w_xfer       = r_tvalid & gen_o_tready;
  assign w_pkt_last   = r_pkt == r_num - LW'(1);
  assign w_next_last  = r_beat == r_len - LW'(2);
  assign w_first_last = r_len == LW'(1);
  assign w_gap_end    = r_gap == GW'(IPG - 1);
  // tlast is precomputed one beat ahead so it is registered alongside tdata
  always_ff @(posedge gen_clk or negedge gen_resetn) begin
    if (!gen_resetn) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_num      <= '0;
      r_beat     <= '0;
      r_pkt      <= '0;
      r_gap      <= '0;
      r_data     <= '0;
      r_beat_cnt <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (gen_start) begin
          if (gen_pkt_len != '0 && gen_pkt_num != '0) begin
            r_state  <= S_SEND;
            r_len    <= gen_pkt_len;
            r_num    <= gen_pkt_num;
            r_data   <= gen_seed;
            r_beat   <= '0;
            r_pkt    <= '0;
            r_tvalid <= 1'b1;
            r_tlast  <= gen_pkt_len == LW'(1);
            r_busy   <= 1'b1;
          end else r_err <= 1'b1;
        end
        S_SEND: if (w_xfer) begin
          r_data     <= r_data + DW'(1);
          r_beat_cnt <= r_beat_cnt + 32'd1;
          if (!r_tlast) begin
            r_beat  <= r_beat + LW'(1);
            r_tlast <= w_next_last;
          end else if (w_pkt_last) begin
            r_state  <= S_DONE;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_pkt  <= r_pkt + LW'(1);
            r_beat <= '0;
            if (IPG == 0) r_tlast <= w_first_last;
            else begin
              r_state  <= S_GAP;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_gap    <= '0;
            end
          end
        end
        S_GAP: if (w_gap_end) begin
          r_state  <= S_SEND;
          r_tvalid <= 1'b1;
          r_tlast  <= w_first_last;
        end else r_gap <= r_gap + GW'(1);
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign gen_busy     = r_busy;
  assign gen_done     = r_done;
  assign gen_err      = r_err;
  assign gen_beat_cnt = r_beat_cnt;
  assign gen_o_tvalid = r_tvalid;
  assign gen_o_tdata  = r_data;
  assign gen_o_tlast  = r_tlast;
  assign gen_o_tkeep  = '1;
  assign gen_o_tdest  = ID;
endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb_axis_pattern_gen: directed self-checking bench; a second instance with IPG=3 covers inter-packet gaps.
module tb_axis_pattern_gen;
  logic        gen_clk = 1'b0, gen_resetn = 1'b0, gen_start = 1'b0, gen_start_g = 1'b0, tready = 1'b1;
  logic [15:0] len = '0, num = '0;
  logic [31:0] seed = '0;
  logic        busy, done, err, tvalid, tlast;
  logic [31:0] beat_cnt, tdata;
  logic [3:0]  tkeep, tdest;
  logic        busy_g, done_g, err_g, tvalid_g, tlast_g;
  logic [31:0] beat_cnt_g, tdata_g;
  logic [3:0]  tkeep_g, tdest_g;
  int errors = 0, checks = 0;
  always #5 gen_clk = ~gen_clk;
  axis_pattern_gen #(.ID(4'h5), .DW(32), .LW(16), .IPG(0)) dut (
    .gen_clk(gen_clk), .gen_resetn(gen_resetn), .gen_start(gen_start), .gen_pkt_len(len),
    .gen_pkt_num(num), .gen_seed(seed), .gen_busy(busy), .gen_done(done), .gen_err(err),
    .gen_beat_cnt(beat_cnt), .gen_o_tvalid(tvalid), .gen_o_tready(tready), .gen_o_tdata(tdata),
    .gen_o_tkeep(tkeep), .gen_o_tdest(tdest), .gen_o_tlast(tlast));
  axis_pattern_gen #(.ID(4'h0), .DW(32), .LW(16), .IPG(3)) dut_g (
    .gen_clk(gen_clk), .gen_resetn(gen_resetn), .gen_start(gen_start_g), .gen_pkt_len(len),
    .gen_pkt_num(num), .gen_seed(seed), .gen_busy(busy_g), .gen_done(done_g), .gen_err(err_g),
    .gen_beat_cnt(beat_cnt_g), .gen_o_tvalid(tvalid_g), .gen_o_tready(tready), .gen_o_tdata(tdata_g),
    .gen_o_tkeep(tkeep_g), .gen_o_tdest(tdest_g), .gen_o_tlast(tlast_g));
  task automatic start_run(input logic [15:0] l, input logic [15:0] n, input logic [31:0] s, input bit g);
    len = l; num = n; seed = s;
    if (g) gen_start_g = 1'b1; else gen_start = 1'b1;
    @(negedge gen_clk);
    gen_start = 1'b0; gen_start_g = 1'b0;
  endtask
  task automatic test_reset;
    checks++; if ({tvalid, tlast, busy, done, err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {tvalid, tlast, busy, done, err}); end
    checks++; if (tdata !== 32'h0 || beat_cnt !== 32'h0) begin errors++; $display("FAIL reset_data: got %h/%h want 0/0", tdata, beat_cnt); end
    checks++; if (tkeep !== 4'hF || tdest !== 4'h5) begin errors++; $display("FAIL reset_keep_dest: got %h/%h want f/5", tkeep, tdest); end
    checks++; if (tvalid_g !== 1'b0 || busy_g !== 1'b0) begin errors++; $display("FAIL reset_g: got %b%b want 00", tvalid_g, busy_g); end
  endtask
  task automatic test_basic;
    tready = 1'b1;
    start_run(16'd4, 16'd2, 32'h100, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (tvalid !== 1'b1 || tdata !== 32'h100 + i) begin errors++; $display("FAIL basic_beat%0d: got v=%b d=%h want v=1 d=%h", i, tvalid, tdata, 32'h100 + i); end
      checks++; if (tlast !== (i == 3 || i == 7)) begin errors++; $display("FAIL basic_tlast%0d: got %b want %b", i, tlast, (i == 3 || i == 7)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy%0d: got %b want 1", i, busy); end
      @(negedge gen_clk);
    end
    checks++; if (done !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done: got d=%b v=%b b=%b want 1 0 0", done, tvalid, busy); end
    checks++; if (beat_cnt !== 32'd8) begin errors++; $display("FAIL basic_cnt: got %0d want 8", beat_cnt); end
    @(negedge gen_clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask
  task automatic test_backpressure;
    int idx = 0, cyc = 0, dn = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;
    start_run(16'd16, 16'd1, 32'h200, 1'b0);
    while (idx < 16 && cyc < 300) begin
      tready = 1'($urandom_range(0, 1));
      if (pv && !pr) begin
        checks++; if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin errors++; $display("FAIL bp_stall: got v=%b d=%h l=%b want v=1 d=%h l=%b", tvalid, tdata, tlast, pd, pl); end
      end
      if (tvalid && tready) begin
        checks++; if (tdata !== 32'h200 + idx || tlast !== (idx == 15)) begin errors++; $display("FAIL bp_beat%0d: got d=%h l=%b want d=%h l=%b", idx, tdata, tlast, 32'h200 + idx, idx == 15); end
        idx++;
      end
      if (done) dn++;
      pv = tvalid; pr = tready; pd = tdata; pl = tlast;
      @(negedge gen_clk);
      cyc++;
    end
    tready = 1'b1;
    checks++; if (idx != 16) begin errors++; $display("FAIL bp_timeout: got %0d beats want 16", idx); end
    if (done) dn++;
    @(negedge gen_clk);
    if (done) dn++;
    checks++; if (dn != 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", dn); end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL bp_idle: got v=%b want 0", tvalid); end
  endtask
  task automatic test_gap;
    logic [11:0] pat = 12'b110001100011;
    logic [31:0] k = '0;
    tready = 1'b1;
    start_run(16'd2, 16'd3, 32'h0, 1'b1);
    for (int c = 0; c < 12; c++) begin
      checks++; if (tvalid_g !== pat[c] || busy_g !== 1'b1) begin errors++; $display("FAIL gap_valid%0d: got v=%b b=%b want v=%b b=1", c, tvalid_g, busy_g, pat[c]); end
      if (pat[c]) begin
        checks++; if (tdata_g !== k || tlast_g !== k[0]) begin errors++; $display("FAIL gap_data%0d: got d=%h l=%b want d=%h l=%b", c, tdata_g, tlast_g, k, k[0]); end
        k++;
      end
      @(negedge gen_clk);
    end
    checks++; if (done_g !== 1'b1 || tvalid_g !== 1'b0 || busy_g !== 1'b0) begin errors++; $display("FAIL gap_done: got d=%b v=%b b=%b want 1 0 0", done_g, tvalid_g, busy_g); end
    checks++; if (beat_cnt_g !== 32'd6 || tdest_g !== 4'h0) begin errors++; $display("FAIL gap_cnt_dest: got %0d/%h want 6/0", beat_cnt_g, tdest_g); end
    @(negedge gen_clk);
  endtask
  task automatic test_reject;
    tready = 1'b1;
    start_run(16'd0, 16'd5, 32'h10, 1'b0);
    checks++; if (err !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rej_len: got e=%b v=%b b=%b want 1 0 0", err, tvalid, busy); end
    @(negedge gen_clk);
    checks++; if (err !== 1'b0 || tvalid !== 1'b0) begin errors++; $display("FAIL rej_len_pulse: got e=%b v=%b want 0 0", err, tvalid); end
    start_run(16'd5, 16'd0, 32'h10, 1'b0);
    checks++; if (err !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rej_num: got e=%b v=%b b=%b want 1 0 0", err, tvalid, busy); end
    @(negedge gen_clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rej_num_pulse: got %b want 0", err); end
    start_run(16'd3, 16'd1, 32'h50, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (tvalid !== 1'b1 || tdata !== 32'h50 + i || err !== 1'b0) begin errors++; $display("FAIL busy_ign%0d: got v=%b d=%h e=%b want 1 %h 0", i, tvalid, tdata, err, 32'h50 + i); end
      gen_start = (i == 0); len = 16'd7; seed = 32'h999;
      @(negedge gen_clk);
    end
    gen_start = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL busy_ign_done: got d=%b e=%b b=%b want 1 0 0", done, err, busy); end
    @(negedge gen_clk);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL busy_ign_idle: got %b want 0", tvalid); end
  endtask
  task automatic test_single_wrap;
    start_run(16'd1, 16'd1, 32'hFFFF_FFFF, 1'b0);
    checks++; if (tvalid !== 1'b1 || tdata !== 32'hFFFF_FFFF || tlast !== 1'b1) begin errors++; $display("FAIL single: got v=%b d=%h l=%b want 1 ffffffff 1", tvalid, tdata, tlast); end
    @(negedge gen_clk);
    checks++; if (done !== 1'b1 || tvalid !== 1'b0) begin errors++; $display("FAIL single_done: got d=%b v=%b want 1 0", done, tvalid); end
    @(negedge gen_clk);
    start_run(16'd2, 16'd1, 32'hFFFF_FFFF, 1'b0);
    checks++; if (tdata !== 32'hFFFF_FFFF || tlast !== 1'b0) begin errors++; $display("FAIL wrap0: got d=%h l=%b want ffffffff 0", tdata, tlast); end
    @(negedge gen_clk);
    checks++; if (tvalid !== 1'b1 || tdata !== 32'h0 || tlast !== 1'b1) begin errors++; $display("FAIL wrap1: got v=%b d=%h l=%b want 1 0 1", tvalid, tdata, tlast); end
    @(negedge gen_clk);
    checks++; if (done !== 1'b1 || beat_cnt !== 32'd30) begin errors++; $display("FAIL wrap_done: got d=%b cnt=%0d want 1 30", done, beat_cnt); end
    @(negedge gen_clk);
  endtask
  task automatic test_reset_mid;
    start_run(16'd10, 16'd1, 32'h700, 1'b0);
    for (int i = 0; i < 4; i++) @(negedge gen_clk);
    checks++; if (tvalid !== 1'b1 || tdata !== 32'h704) begin errors++; $display("FAIL mid_beat5: got v=%b d=%h want 1 704", tvalid, tdata); end
    #1 gen_resetn = 1'b0;
    #1;
    checks++; if ({tvalid, tlast, busy, done} !== 4'b0 || tdata !== 32'h0 || beat_cnt !== 32'h0) begin errors++; $display("FAIL mid_reset: got f=%b d=%h c=%h want 0000 0 0", {tvalid, tlast, busy, done}, tdata, beat_cnt); end
    @(negedge gen_clk);
    gen_resetn = 1'b1;
    @(negedge gen_clk);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b want 0", tvalid); end
    start_run(16'd2, 16'd1, 32'h123, 1'b0);
    checks++; if (tvalid !== 1'b1 || tdata !== 32'h123 || tlast !== 1'b0) begin errors++; $display("FAIL mid_rerun0: got v=%b d=%h l=%b want 1 123 0", tvalid, tdata, tlast); end
    @(negedge gen_clk);
    checks++; if (tdata !== 32'h124 || tlast !== 1'b1) begin errors++; $display("FAIL mid_rerun1: got d=%h l=%b want 124 1", tdata, tlast); end
    @(negedge gen_clk);
    checks++; if (done !== 1'b1 || beat_cnt !== 32'd2) begin errors++; $display("FAIL mid_rerun_done: got d=%b c=%0d want 1 2", done, beat_cnt); end
  endtask
  initial begin
    #3;
    test_reset;
    @(negedge gen_clk);
    gen_resetn = 1'b1;
    @(negedge gen_clk);
    test_basic;
    test_backpressure;
    test_gap;
    test_reject;
    test_single_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
